// File: rtl/ysyx_24110015_ifu_prefetch_pkg.sv
// Shared constants and types for the prefetching instruction fetch unit.
// The FSM encoding is 2 bits so busy and debug probes can decode it directly.
package ysyx_24110015_ifu_prefetch_pkg;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StAr    = 2'b01,
      StR     = 2'b10,
      StDrain = 2'b11
   } ifu_state_e;

   function automatic logic resp_is_fault(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/ysyx_24110015_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; the head entry is presented on rdata while not empty.
// Callers guarantee no push when full unless a pop happens in the same cycle.
module ysyx_24110015_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   input  logic                    flush,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] DepthCnt = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;

   // Pointers are log2(DEPTH) bits wide and wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = mem[rd_ptr_q];
   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// Prefetching IFU: AXI4-Lite read master filling a small queue of {pc, inst, fault} toward the IDU.
// One read is outstanding at a time; a redirect flushes the queue and squashes any in-flight beat.
module ysyx_24110015_ifu_prefetch
   import ysyx_24110015_ifu_prefetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] araddr,
   output logic            arvalid,
   input  logic            arready,
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      rresp,
   input  logic            rvalid,
   output logic            rready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault,
   output logic            busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = 2 * XLEN + 1;
   localparam logic [PW:0] DepthCnt = (PW+1)'(DEPTH);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] ar_addr_q, ar_addr_d;
   logic            halted_q, halted_d;
   logic            squash_q, squash_d;
   logic            q_push, q_pop, q_full, q_empty;
   logic [EW-1:0]   q_wdata, q_rdata;
   logic [PW:0]     q_count;
   logic            unused_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (!redirect_valid && !halted_q && (q_count < DepthCnt)) state_d = StAr;
         StAr:    if (arready) state_d = (squash_q || redirect_valid) ? StDrain : StR;
         StR: begin
            if (rvalid)              state_d = StIdle;
            else if (redirect_valid) state_d = StDrain;
         end
         StDrain: if (rvalid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      arvalid = (state_q == StAr);
      rready  = (state_q == StR) || (state_q == StDrain);
      busy    = (state_q != StIdle);
   end

   // ar_addr is latched at issue so araddr stays stable even if a redirect moves fetch_pc.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      ar_addr_d  = ar_addr_q;
      halted_d   = halted_q;
      squash_d   = squash_q;
      q_push     = 1'b0;
      if (state_q == StIdle && state_d == StAr) ar_addr_d = fetch_pc_q;
      // A redirect seen while AR is pending turns the eventual beat into a drain.
      if (state_q == StAr) squash_d = !arready && (squash_q || redirect_valid);
      if (state_q == StR && rvalid && !redirect_valid) begin
         q_push     = 1'b1;
         fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         if (resp_is_fault(rresp)) halted_d = 1'b1;
      end
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         halted_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         ar_addr_q  <= RESET_PC;
         halted_q   <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         ar_addr_q  <= ar_addr_d;
         halted_q   <= halted_d;
         squash_q   <= squash_d;
      end
   end

   assign araddr  = ar_addr_q;
   assign q_wdata = {ar_addr_q, rdata, resp_is_fault(rresp)};
   assign q_pop   = out_valid && out_ready && !redirect_valid;

   ysyx_24110015_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .wdata (q_wdata),
      .pop   (q_pop),
      .flush (redirect_valid),
      .rdata (q_rdata),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   // Fetch gating uses the count compare; full is kept on the queue interface for other users.
   assign unused_full = q_full;

   assign out_valid = !q_empty;
   assign out_pc    = q_rdata[EW-1 -: XLEN];
   assign out_inst  = q_rdata[XLEN:1];
   assign out_fault = q_rdata[0];

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// Self-checking bench for the prefetching IFU: AXI slave model plus an in-order pc scoreboard.
// Directed scenarios cover stall, redirect, fault and reset; a random phase mixes them.
module tb_ysyx_24110015_ifu_prefetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        busy;

   always #5 clk = ~clk;

   ysyx_24110015_ifu_prefetch dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .araddr         (araddr),
      .arvalid        (arvalid),
      .arready        (arready),
      .rdata          (rdata),
      .rresp          (rresp),
      .rvalid         (rvalid),
      .rready         (rready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_fault      (out_fault),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Slave configuration (negative latency = random 0..3) and model state.
   int          ar_lat_fix = 0;
   int          r_lat_fix  = 0;
   bit          err_en     = 1'b0;
   logic [31:0] err_pc     = '0;
   logic [31:0] salt       = 32'h0000_A5A5;
   int          ar_wait, cur_ar_lat, r_wait, cur_r_lat;
   bit          pend_valid;
   logic [31:0] pend_addr;
   int          n_ar, n_pop;
   logic [31:0] exp_pc;
   bit          prev_hold_ar, prev_hold_out;
   logic [31:0] prev_araddr, prev_pc, prev_inst;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ salt;
   endfunction

   // One clock: sample at negedge, drive slave, score pops, advance to next negedge.
   task automatic cycle();
      logic [31:0] ar_addr_s;
      bit          ar_hs, r_hs, arv_s;
      if (prev_hold_ar) begin
         check("ar_hold_valid", 32'(arvalid), 32'd1);
         check("ar_hold_addr", araddr, prev_araddr);
      end
      if (prev_hold_out) begin
         check("out_hold_valid", 32'(out_valid), 32'd1);
         check("out_hold_pc", out_pc, prev_pc);
         check("out_hold_inst", out_inst, prev_inst);
      end
      if (out_valid && out_fault) check("halt_no_ar", 32'(arvalid), 32'd0);

      if (arvalid && ar_wait == 0)
         cur_ar_lat = (ar_lat_fix < 0) ? int'($urandom_range(0, 3)) : ar_lat_fix;
      arready = arvalid && !pend_valid && (ar_wait >= cur_ar_lat);
      rvalid  = pend_valid && (r_wait >= cur_r_lat);
      rdata   = mem_word(pend_addr);
      rresp   = (err_en && pend_addr == err_pc) ? 2'b10 : 2'b00;
      ar_hs     = arvalid && arready;
      r_hs      = rvalid && rready;
      arv_s     = arvalid;
      ar_addr_s = araddr;

      if (redirect_valid) begin
         exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (out_valid && out_ready) begin
         check("pop_pc", out_pc, exp_pc);
         check("pop_inst", out_inst, mem_word(exp_pc));
         check("pop_fault", 32'(out_fault), 32'(err_en && exp_pc == err_pc));
         exp_pc += 32'd4;
         n_pop++;
      end
      prev_hold_ar  = arvalid && !arready;
      prev_araddr   = araddr;
      prev_hold_out = out_valid && !out_ready && !redirect_valid;
      prev_pc       = out_pc;
      prev_inst     = out_inst;

      @(posedge clk);
      if (ar_hs) begin
         pend_valid = 1'b1;
         pend_addr  = ar_addr_s;
         r_wait     = 0;
         cur_r_lat  = (r_lat_fix < 0) ? int'($urandom_range(0, 3)) : r_lat_fix;
         n_ar++;
      end else if (pend_valid) begin
         r_wait++;
      end
      if (r_hs) pend_valid = 1'b0;
      ar_wait = (arv_s && !ar_hs) ? ar_wait + 1 : 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      arready = 1'b0;
      rvalid = 1'b0;
      rdata = '0;
      rresp = '0;
      pend_valid = 1'b0;
      pend_addr = '0;
      ar_wait = 0;
      r_wait = 0;
      cur_ar_lat = 0;
      cur_r_lat = 0;
      prev_hold_ar = 1'b0;
      prev_hold_out = 1'b0;
      exp_pc = RST_PC;
      n_ar = 0;
      repeat (2) @(negedge clk);
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      int p0, n0;

      // 1: sequential fetch, zero-latency memory, always-ready consumer.
      salt = 32'h0000_A5A5;
      out_ready = 1'b1;
      n_pop = 0;
      do_reset();
      cycle();
      check("t1_first_arvalid", 32'(arvalid), 32'd1);
      check("t1_first_araddr", araddr, RST_PC);
      repeat (40) cycle();
      check("t1_progress", 32'(n_pop >= 10), 32'd1);

      // 2: consumer stalled, queue fills to DEPTH then fetch stops.
      out_ready = 1'b0;
      do_reset();
      repeat (40) cycle();
      check("t2_ar_count", 32'(n_ar), 32'd4);
      check("t2_arvalid_idle", 32'(arvalid), 32'd0);
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_head_pc", out_pc, RST_PC);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      repeat (10) cycle();
      check("t2_refetch_one", 32'(n_ar), 32'd5);
      check("t2_arvalid_after", 32'(arvalid), 32'd0);

      // 3: redirect while in R before the beat arrives.
      do_reset();
      r_lat_fix = 6;
      for (int i = 0; i < 100 && !(rready && out_valid); i++) cycle();
      check("t3_reach_r", 32'(rready && out_valid && !rvalid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0102;
      cycle();
      redirect_valid = 1'b0;
      check("t3_flushed", 32'(out_valid), 32'd0);
      for (int i = 0; i < 40 && !arvalid; i++) cycle();
      check("t3_new_araddr", araddr, 32'h8000_0100);
      r_lat_fix = 0;
      out_ready = 1'b1;
      repeat (20) cycle();

      // 4: redirect in AR while arready is held off for 3 cycles.
      ar_lat_fix = 3;
      do_reset();
      for (int i = 0; i < 20 && !arvalid; i++) cycle();
      check("t4_reach_ar", 32'(arvalid), 32'd1);
      n0 = n_ar;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0200;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10 && n_ar == n0; i++) begin
         check("t4_hold_valid", 32'(arvalid), 32'd1);
         check("t4_hold_addr", araddr, RST_PC);
         cycle();
      end
      check("t4_one_handshake", 32'(n_ar), 32'(n0 + 1));
      for (int i = 0; i < 40 && !arvalid; i++) cycle();
      check("t4_new_araddr", araddr, 32'h8000_0200);
      repeat (20) cycle();
      ar_lat_fix = 0;

      // 5: error response halts fetch until a redirect.
      err_en = 1'b1;
      err_pc = 32'h8000_0008;
      do_reset();
      for (int i = 0; i < 60 && !(out_valid && out_fault); i++) cycle();
      out_ready = 1'b0;
      check("t5_fault_head", 32'(out_fault), 32'd1);
      check("t5_fault_pc", out_pc, 32'h8000_0008);
      n0 = n_ar;
      repeat (10) cycle();
      check("t5_no_more_ar", 32'(n_ar), 32'(n0));
      check("t5_busy_idle", 32'(busy), 32'd0);
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = RST_PC;
      cycle();
      redirect_valid = 1'b0;
      p0 = n_pop;
      repeat (15) cycle();
      check("t5_resumed", 32'(n_pop - p0 >= 2), 32'd1);
      err_en = 1'b0;

      // 6: asynchronous reset in R with a nearly full queue.
      out_ready = 1'b0;
      r_lat_fix = 3;
      do_reset();
      for (int i = 0; i < 100 && !(rready && n_ar == 4); i++) cycle();
      check("t6_reach_r", 32'(rready && n_ar == 4), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_async_out_valid", 32'(out_valid), 32'd0);
      check("t6_async_rready", 32'(rready), 32'd0);
      @(negedge clk);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_arvalid", 32'(arvalid), 32'd0);
      do_reset();
      for (int i = 0; i < 10 && !arvalid; i++) cycle();
      check("t6_restart_pc", araddr, RST_PC);
      r_lat_fix = 0;
      out_ready = 1'b1;
      repeat (20) cycle();

      // Random phase: random latencies, backpressure, redirects and error responses.
      ar_lat_fix = -1;
      r_lat_fix = -1;
      err_en = 1'b1;
      err_pc = RST_PC + 32'(4 * $urandom_range(5, 40));
      salt = $urandom;
      do_reset();
      p0 = n_pop;
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 99) < 3);
         if (redirect_valid) redirect_pc = RST_PC + 32'($urandom_range(0, 255));
         cycle();
         redirect_valid = 1'b0;
      end
      check("rand_progress", 32'(n_pop - p0 >= 200), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
